// File: rtl/coolie_pkg.sv
// Shared types, constants and trellis helpers for the coolie rate-1/2, K=3 (7/5)
// hard-decision Viterbi frame decoder.
package coolie_pkg;

  localparam int NUM_SYM    = 5;
  localparam int NUM_STATES = 4;
  localparam int METRIC_W   = 5;
  localparam int CNT_W      = 3;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  localparam logic [METRIC_W-1:0] METRIC_INIT_UNREACH = 5'd16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    LOAD      = 3'd2,
    ACS       = 3'd3,
    TRACEBACK = 3'd4,
    DONE      = 3'd5
  } state_e;

  typedef logic [METRIC_W-1:0] metric_t;
  typedef logic [NUM_STATES-1:0][METRIC_W-1:0] metric_vec_t;

  // Encoder output for trellis state {s1,s0} driven by input bit u.
  function automatic logic [1:0] expected_sym(input logic [1:0] st, input logic u);
    logic [2:0] sr;
    sr = {u, st};
    return {^(sr & G0), ^(sr & G1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage

// File: rtl/coolie_acs_unit.sv
// Combinational add-compare-select over the 4-state trellis for one received symbol.
module coolie_acs_unit
  import coolie_pkg::*;
(
  input  metric_vec_t             metric_in,
  input  logic [1:0]              rx_sym,
  output metric_vec_t             metric_out,
  output logic [NUM_STATES-1:0]   surv
);

  // New state (u,b) is reached from (b,0) or (b,1); ties keep (b,0).
  always_comb begin
    metric_out = '0;
    surv       = '0;
    for (int n = 0; n < NUM_STATES; n++) begin
      logic [1:0] ns;
      logic [1:0] p0;
      logic [1:0] p1;
      metric_t    c0;
      metric_t    c1;
      ns = 2'(n);
      p0 = {ns[0], 1'b0};
      p1 = {ns[0], 1'b1};
      c0 = metric_in[p0] + metric_t'(hamming2(rx_sym, expected_sym(p0, ns[1])));
      c1 = metric_in[p1] + metric_t'(hamming2(rx_sym, expected_sym(p1, ns[1])));
      if (c1 < c0) begin
        metric_out[n] = c1;
        surv[n]       = 1'b1;
      end else begin
        metric_out[n] = c0;
        surv[n]       = 1'b0;
      end
    end
  end

endmodule

// File: rtl/coolie_decoder.sv
// Single-frame Viterbi decoder: loads NUM_SYM symbols, runs one ACS step per cycle,
// then traces back one step per cycle and holds results until reset.
module coolie_decoder
  import coolie_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             in_sym,
  input  logic                   in_valid,
  output logic [2*NUM_SYM-1:0]   recv_sym_out,
  output logic [2*NUM_SYM-1:0]   corrected_codeword,
  output logic [NUM_SYM-1:0]     decoded_bits,
  output logic                   done
);

  state_e                              state, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  metric_vec_t                         metric_q, metric_d, acs_metric;
  logic [NUM_STATES-1:0]               acs_surv;
  logic [NUM_SYM-1:0][NUM_STATES-1:0]  surv_q, surv_d;
  logic [1:0]                          tb_state_q, tb_state_d;
  logic [2*NUM_SYM-1:0]                recv_q, recv_d;
  logic [2*NUM_SYM-1:0]                cw_acc_q, cw_acc_d, cw_q, cw_d;
  logic [NUM_SYM-1:0]                  dec_acc_q, dec_acc_d, dec_q, dec_d;
  logic                                done_q, done_d;
  logic [1:0]                          cur_sym;
  logic                                last_cnt;
  logic                                tb_u;
  logic [1:0]                          tb_prev;

  function automatic logic [1:0] best_state(input metric_vec_t m);
    logic [1:0] idx;
    metric_t    best;
    idx  = 2'd0;
    best = m[0];
    for (int i = 1; i < NUM_STATES; i++) begin
      if (m[i] < best) begin
        best = m[i];
        idx  = 2'(i);
      end else begin
        best = best;
      end
    end
    return idx;
  endfunction

  assign last_cnt = (cnt_q == CNT_W'(NUM_SYM - 1));

  coolie_acs_unit u_acs (
    .metric_in  (metric_q),
    .rx_sym     (cur_sym),
    .metric_out (acs_metric),
    .surv       (acs_surv)
  );

  // Symbol selected by the shared counter; symbol 0 sits in the top bits.
  always_comb begin
    cur_sym = 2'b00;
    for (int i = 0; i < NUM_SYM; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        cur_sym = recv_q[2*(NUM_SYM-1-i) +: 2];
      end else begin
        cur_sym = cur_sym;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      state_d = INIT;
      INIT:      state_d = LOAD;
      LOAD:      state_d = (in_valid && last_cnt) ? ACS : LOAD;
      ACS:       state_d = last_cnt ? TRACEBACK : ACS;
      TRACEBACK: state_d = (cnt_q == '0) ? DONE : TRACEBACK;
      DONE:      state_d = DONE;
      default:   state_d = IDLE;
    endcase
  end

  // Traceback walks from the final step to the first: the current state's s1 is the
  // decoded bit, and the survivor bit restores the predecessor's s0.
  assign tb_u    = tb_state_q[1];
  assign tb_prev = {tb_state_q[0], surv_q[cnt_q][tb_state_q]};

  always_comb begin
    cnt_d      = cnt_q;
    metric_d   = metric_q;
    surv_d     = surv_q;
    tb_state_d = tb_state_q;
    recv_d     = recv_q;
    cw_acc_d   = cw_acc_q;
    dec_acc_d  = dec_acc_q;
    cw_d       = cw_q;
    dec_d      = dec_q;
    case (state)
      IDLE: begin
        cnt_d = '0;
      end
      INIT: begin
        metric_d = {METRIC_INIT_UNREACH, METRIC_INIT_UNREACH, METRIC_INIT_UNREACH, metric_t'(0)};
        cnt_d    = '0;
      end
      LOAD: begin
        if (in_valid) begin
          for (int i = 0; i < NUM_SYM; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              recv_d[2*(NUM_SYM-1-i) +: 2] = in_sym;
            end else begin
              recv_d = recv_d;
            end
          end
          cnt_d = last_cnt ? '0 : cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ACS: begin
        metric_d        = acs_metric;
        surv_d[cnt_q]   = acs_surv;
        if (last_cnt) begin
          tb_state_d = best_state(acs_metric);
          cnt_d      = CNT_W'(NUM_SYM - 1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TRACEBACK: begin
        for (int i = 0; i < NUM_SYM; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            dec_acc_d[NUM_SYM-1-i]          = tb_u;
            cw_acc_d[2*(NUM_SYM-1-i) +: 2]  = expected_sym(tb_prev, tb_u);
          end else begin
            dec_acc_d = dec_acc_d;
          end
        end
        tb_state_d = tb_prev;
        if (cnt_q == '0) begin
          dec_d = dec_acc_d;
          cw_d  = cw_acc_d;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign done_d = (state_d == DONE);

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      metric_q   <= '0;
      surv_q     <= '0;
      tb_state_q <= 2'b00;
      recv_q     <= '0;
      cw_acc_q   <= '0;
      dec_acc_q  <= '0;
      cw_q       <= '0;
      dec_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      metric_q   <= metric_d;
      surv_q     <= surv_d;
      tb_state_q <= tb_state_d;
      recv_q     <= recv_d;
      cw_acc_q   <= cw_acc_d;
      dec_acc_q  <= dec_acc_d;
      cw_q       <= cw_d;
      dec_q      <= dec_d;
      done_q     <= done_d;
    end
  end

  assign recv_sym_out       = recv_q;
  assign corrected_codeword = cw_q;
  assign decoded_bits       = dec_q;
  assign done               = done_q;

endmodule

// File: tb/tb_coolie_decoder.sv
// Directed self-checking bench for coolie_decoder with hand-computed frames.
module tb_coolie_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_sym = 2'b00;
  logic [9:0] recv_sym_out;
  logic [9:0] corrected_codeword;
  logic [4:0] decoded_bits;
  logic       done;

  int checks   = 0;
  int failures = 0;

  coolie_decoder dut (
    .clk                (clk),
    .rst                (rst),
    .in_sym             (in_sym),
    .in_valid           (in_valid),
    .recv_sym_out       (recv_sym_out),
    .corrected_codeword (corrected_codeword),
    .decoded_bits       (decoded_bits),
    .done               (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; in_valid = 1'b0; in_sym = 2'b00;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic wait_load(input string name);
    int n = 0;
    while (dut.state !== 3'd2 && n < 20) begin tick; n++; end
    checks++;
    if (dut.state !== 3'd2) begin failures++; $display("FAIL %s_wait_load state=%0d exp=2", name, dut.state); end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin tick; n++; end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL %s_wait_done done=%b exp=1", name, done); end
  endtask

  task automatic send_frame(input logic [9:0] f, input int gap);
    for (int k = 0; k < 5; k++) begin
      in_sym = f[9-2*k -: 2]; in_valid = 1'b1;
      tick;
      in_valid = 1'b0; in_sym = 2'b00;
      for (int g = 0; g < gap; g++) tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tick; tick;
    checks++; if (recv_sym_out !== 10'd0) begin failures++; $display("FAIL rst_recv got=%b exp=0", recv_sym_out); end
    checks++; if (corrected_codeword !== 10'd0) begin failures++; $display("FAIL rst_cw got=%b exp=0", corrected_codeword); end
    checks++; if (decoded_bits !== 5'd0) begin failures++; $display("FAIL rst_dec got=%b exp=0", decoded_bits); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (dut.state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dut.state); end
    rst = 1'b0; tick;
    checks++; if (dut.state !== 3'd1) begin failures++; $display("FAIL rst_init got=%0d exp=1", dut.state); end
    tick;
    checks++; if (dut.state !== 3'd2) begin failures++; $display("FAIL rst_load got=%0d exp=2", dut.state); end
  endtask

  task automatic test_frame_gap;
    apply_reset; wait_load("gap");
    send_frame(10'b1011001100, 1);
    wait_done("gap");
    checks++; if (recv_sym_out !== 10'b1011001100) begin failures++; $display("FAIL gap_recv got=%b exp=1011001100", recv_sym_out); end
    checks++; if (corrected_codeword !== 10'b0011101100) begin failures++; $display("FAIL gap_cw got=%b exp=0011101100", corrected_codeword); end
    checks++; if (decoded_bits !== 5'b01000) begin failures++; $display("FAIL gap_dec got=%b exp=01000", decoded_bits); end
  endtask

  task automatic test_all_zero;
    apply_reset; wait_load("zero");
    send_frame(10'b0000000000, 0);
    wait_done("zero");
    checks++; if (corrected_codeword !== 10'b0000000000) begin failures++; $display("FAIL zero_cw got=%b exp=0000000000", corrected_codeword); end
    checks++; if (decoded_bits !== 5'b00000) begin failures++; $display("FAIL zero_dec got=%b exp=00000", decoded_bits); end
  endtask

  task automatic test_back_to_back;
    apply_reset; wait_load("b2b");
    send_frame(10'b1110000101, 0);
    repeat (9) tick;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_early_done got=%b exp=0", done); end
    checks++; if (decoded_bits !== 5'b00000) begin failures++; $display("FAIL b2b_early_dec got=%b exp=00000", decoded_bits); end
    tick;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", done); end
    checks++; if (decoded_bits !== 5'b10110) begin failures++; $display("FAIL b2b_dec got=%b exp=10110", decoded_bits); end
    checks++; if (corrected_codeword !== 10'b1110000101) begin failures++; $display("FAIL b2b_cw got=%b exp=1110000101", corrected_codeword); end
    checks++; if (recv_sym_out !== 10'b1110000101) begin failures++; $display("FAIL b2b_recv got=%b exp=1110000101", recv_sym_out); end
  endtask

  task automatic test_single_error;
    apply_reset; wait_load("err1");
    send_frame(10'b0110000101, 0);
    wait_done("err1");
    checks++; if (decoded_bits !== 5'b10110) begin failures++; $display("FAIL err1_dec got=%b exp=10110", decoded_bits); end
    checks++; if (corrected_codeword !== 10'b1110000101) begin failures++; $display("FAIL err1_cw got=%b exp=1110000101", corrected_codeword); end
    checks++; if (recv_sym_out !== 10'b0110000101) begin failures++; $display("FAIL err1_recv got=%b exp=0110000101", recv_sym_out); end
  endtask

  task automatic test_ignored_valid;
    rst = 1'b1; in_valid = 1'b0; tick; tick;
    rst = 1'b0; in_valid = 1'b1; in_sym = 2'b11;
    tick;
    checks++; if (recv_sym_out !== 10'd0) begin failures++; $display("FAIL ign_idle_recv got=%b exp=0", recv_sym_out); end
    tick;
    checks++; if (recv_sym_out !== 10'd0) begin failures++; $display("FAIL ign_init_recv got=%b exp=0", recv_sym_out); end
    checks++; if (dut.state !== 3'd2) begin failures++; $display("FAIL ign_load_state got=%0d exp=2", dut.state); end
    in_valid = 1'b0; in_sym = 2'b00;
    send_frame(10'b1011001100, 0);
    in_valid = 1'b1; in_sym = 2'b11;
    repeat (3) tick;
    in_valid = 1'b0; in_sym = 2'b00;
    checks++; if (recv_sym_out !== 10'b1011001100) begin failures++; $display("FAIL ign_after_recv got=%b exp=1011001100", recv_sym_out); end
    wait_done("ign");
    checks++; if (decoded_bits !== 5'b01000) begin failures++; $display("FAIL ign_dec got=%b exp=01000", decoded_bits); end
  endtask

  task automatic test_mid_reset;
    apply_reset; wait_load("mid");
    in_sym = 2'b11; in_valid = 1'b1;
    repeat (3) tick;
    in_valid = 1'b0; in_sym = 2'b00;
    checks++; if (recv_sym_out !== 10'b1111110000) begin failures++; $display("FAIL mid_partial got=%b exp=1111110000", recv_sym_out); end
    rst = 1'b1; tick;
    checks++; if (recv_sym_out !== 10'd0) begin failures++; $display("FAIL mid_rst_recv got=%b exp=0", recv_sym_out); end
    checks++; if (dut.state !== 3'd0) begin failures++; $display("FAIL mid_rst_state got=%0d exp=0", dut.state); end
    rst = 1'b0;
    wait_load("mid2");
    send_frame(10'b1110000101, 0);
    wait_done("mid2");
    checks++; if (decoded_bits !== 5'b10110) begin failures++; $display("FAIL mid_dec got=%b exp=10110", decoded_bits); end
    checks++; if (corrected_codeword !== 10'b1110000101) begin failures++; $display("FAIL mid_cw got=%b exp=1110000101", corrected_codeword); end
    in_valid = 1'b1; in_sym = 2'b01;
    repeat (5) tick;
    in_valid = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL mid_hold_done got=%b exp=1", done); end
    checks++; if (decoded_bits !== 5'b10110) begin failures++; $display("FAIL mid_hold_dec got=%b exp=10110", decoded_bits); end
    checks++; if (recv_sym_out !== 10'b1110000101) begin failures++; $display("FAIL mid_hold_recv got=%b exp=1110000101", recv_sym_out); end
    rst = 1'b1; tick;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_final_done got=%b exp=0", done); end
    checks++; if (decoded_bits !== 5'd0) begin failures++; $display("FAIL mid_final_dec got=%b exp=0", decoded_bits); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_frame_gap;
    test_all_zero;
    test_back_to_back;
    test_single_error;
    test_ignored_valid;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
